// File: rtl/mac_writeback_3.sv
// Stage-3 MLP consumer: multiply-accumulates neuron x weight terms, requantizes each finished
// neuron through a two-stage write pipeline and signals layer completion after the writes drain.
module mac_writeback_3 #(
  parameter int ACC_W   = 32,
  parameter int SHIFT   = 7,
  parameter int RELU_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        done_3,
  input  logic [15:0] neuron_val_3,
  input  logic [7:0]  weight_val_3,
  input  logic        reset_mult_acc_3,
  input  logic [11:0] out_neuron_addr_3,
  input  logic        write_neuron_3,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        layer_done,
  output logic        busy,
  output logic [11:0] neuron_count
);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, DONE} state_t;

  state_t state, state_nxt;
  logic   flush_cnt;
  logic   active;

  logic signed [23:0]      neuron_ext, weight_ext, product;
  logic signed [ACC_W-1:0] product_ext;
  logic signed [ACC_W-1:0] acc, acc_nxt;

  logic signed [ACC_W-1:0] acc_p0;
  logic [11:0]             addr_p0;
  logic                    vld_p0;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  function automatic logic [15:0] requant(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] r;
    r = a >>> SHIFT;
    if (RELU_EN != 0 && r < 0) r = '0;
    if (r > SAT_MAX) r = SAT_MAX;
    else if (r < SAT_MIN) r = SAT_MIN;
    return r[15:0];
  endfunction

  assign active = (state == ACTIVE);
  assign busy   = (state == ACTIVE) || (state == FLUSH);

  assign neuron_ext  = {{8{neuron_val_3[15]}}, neuron_val_3};
  assign weight_ext  = {{16{weight_val_3[7]}}, weight_val_3};
  assign product     = neuron_ext * weight_ext;
  assign product_ext = ACC_W'(product);
  assign acc_nxt     = (reset_mult_acc_3 ? '0 : acc) + product_ext;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = ACTIVE;
      ACTIVE:  if (done_3) state_nxt = FLUSH;
      FLUSH:   if (flush_cnt) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // run low behaves like reset except that neuron_count survives until the next layer starts
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      state      <= IDLE;
      flush_cnt  <= 1'b0;
      vld_p0     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      layer_done <= 1'b0;
      acc        <= '0;
      if (reset) neuron_count <= '0;
    end else begin
      state      <= state_nxt;
      flush_cnt  <= (state == FLUSH) ? ~flush_cnt : 1'b0;
      layer_done <= (state == FLUSH) && flush_cnt;
      if (active) acc <= acc_nxt;
      // stage A -> stage B boundary
      vld_p0 <= active && write_neuron_3;
      mem_we <= vld_p0;
      if (vld_p0) begin
        mem_addr  <= addr_p0;
        mem_wdata <= requant(acc_p0);
      end
      if (state == IDLE) neuron_count <= '0;
      else if (vld_p0)   neuron_count <= neuron_count + 12'd1;
    end
  end

  // stage A: capture the finished sum and its address
  always_ff @(posedge clk) begin
    if (active && write_neuron_3) begin
      acc_p0  <= acc_nxt;
      addr_p0 <= out_neuron_addr_3;
    end
  end

endmodule

// File: tb/tb_mac_writeback_3.sv
// Self-checking bench for mac_writeback_3: constant vectors, hand-written corner sequences and
// randomized layers checked against a scheduled-expectation reference model.
module tb_mac_writeback_3;

  logic        clk = 1'b0;
  logic        reset, run, done_3, reset_mult_acc_3, write_neuron_3;
  logic [15:0] neuron_val_3;
  logic [7:0]  weight_val_3;
  logic [11:0] out_neuron_addr_3;
  logic        mem_we, layer_done, busy;
  logic [11:0] mem_addr, neuron_count;
  logic [15:0] mem_wdata;
  logic        nr_we, nr_layer_done, nr_busy;
  logic [11:0] nr_addr, nr_count;
  logic [15:0] nr_wdata;

  mac_writeback_3 #(.ACC_W(32), .SHIFT(7), .RELU_EN(1)) dut (
    .clk(clk), .reset(reset), .run(run), .done_3(done_3),
    .neuron_val_3(neuron_val_3), .weight_val_3(weight_val_3),
    .reset_mult_acc_3(reset_mult_acc_3), .out_neuron_addr_3(out_neuron_addr_3),
    .write_neuron_3(write_neuron_3), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .layer_done(layer_done), .busy(busy),
    .neuron_count(neuron_count));

  mac_writeback_3 #(.ACC_W(32), .SHIFT(7), .RELU_EN(0)) dut_nr (
    .clk(clk), .reset(reset), .run(run), .done_3(done_3),
    .neuron_val_3(neuron_val_3), .weight_val_3(weight_val_3),
    .reset_mult_acc_3(reset_mult_acc_3), .out_neuron_addr_3(out_neuron_addr_3),
    .write_neuron_3(write_neuron_3), .mem_we(nr_we), .mem_addr(nr_addr),
    .mem_wdata(nr_wdata), .layer_done(nr_layer_done), .busy(nr_busy),
    .neuron_count(nr_count));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0, miscompares = 0;

  // expected outputs scheduled per cycle number
  bit          exp_we [8192];
  logic [11:0] exp_addr [8192];
  logic [15:0] exp_d1 [8192];
  logic [15:0] exp_d0 [8192];
  bit          exp_ld [8192];

  bit mon_en = 1'b0;
  bit mact   = 1'b0;
  int msum   = 0;
  int mcount = 0;

  typedef struct {
    int          n;
    int          w;
    logic [15:0] q_relu;
    logic [15:0] q_norelu;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // sum >>> 7 as floor division, then optional ReLU and 16-bit clamp
  function automatic logic [15:0] ref_q(input int s, input bit relu);
    longint q;
    if (s >= 0) q = longint'(s) / 128;
    else        q = -((-longint'(s) + 127) / 128);
    if (relu && q < 0) q = 0;
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mem_we", mem_we, exp_we[cyc]);
      chk("layer_done", layer_done, exp_ld[cyc]);
      if (exp_we[cyc]) begin
        chk("mem_addr", mem_addr, exp_addr[cyc]);
        chk("mem_wdata", mem_wdata, exp_d1[cyc]);
        chk("mem_wdata_norelu", nr_wdata, exp_d0[cyc]);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int n, input int w, input bit r, input bit wr, input int addr,
                      input bit dn);
    neuron_val_3      = n[15:0];
    weight_val_3      = w[7:0];
    reset_mult_acc_3  = r;
    write_neuron_3    = wr;
    out_neuron_addr_3 = addr[11:0];
    done_3            = dn;
    if (mact) begin
      msum = (r ? 0 : msum) + n * w;
      if (wr) begin
        exp_we[cyc+2]   = 1'b1;
        exp_addr[cyc+2] = addr[11:0];
        exp_d1[cyc+2]   = ref_q(msum, 1'b1);
        exp_d0[cyc+2]   = ref_q(msum, 1'b0);
        mcount++;
      end
      if (dn) begin
        exp_ld[cyc+3] = 1'b1;
        mact = 1'b0;
      end
    end
    tick();
  endtask

  task automatic idle_beat;
    beat(0, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic cancel;
    for (int i = cyc + 1; i < cyc + 6; i++) begin
      exp_we[i] = 1'b0;
      exp_ld[i] = 1'b0;
    end
  endtask

  task automatic start;
    run = 1'b0;
    reset = 1'b0;
    cancel();
    mact = 1'b0;
    idle_beat();
    run = 1'b1;
    tick();
    mact = 1'b1;
    msum = 0;
    mcount = 0;
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{-1000,   100, 16'h0000, 16'hFCF2};
    tbl[1] = '{32767,   127, 16'h7EFF, 16'h7EFF};
    tbl[2] = '{256,       2, 16'h0004, 16'h0004};
    tbl[3] = '{-32768, -128, 16'h7FFF, 16'h7FFF};
    tbl[4] = '{-32768,  127, 16'h0000, 16'h8100};
    tbl[5] = '{-1,        1, 16'h0000, 16'hFFFF};
    tbl[6] = '{128,       1, 16'h0001, 16'h0001};
    tbl[7] = '{127,       1, 16'h0000, 16'h0000};
    tbl[8] = '{32767,  -128, 16'h0000, 16'h8001};
    tbl[9] = '{-32768,   -1, 16'h0100, 16'h0100};

    reset = 1'b1; run = 1'b0; done_3 = 1'b0; reset_mult_acc_3 = 1'b0; write_neuron_3 = 1'b0;
    neuron_val_3 = '0; weight_val_3 = '0; out_neuron_addr_3 = '0;
    tick(); tick();
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_layer_done", layer_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_neuron_count", neuron_count, 0);

    start();
    beat(256, 2, 1'b1, 1'b0, 0, 1'b0);
    beat(128, -1, 1'b0, 1'b0, 0, 1'b0);
    beat(512, 1, 1'b0, 1'b1, 5, 1'b0);
    idle_beat();
    @(negedge clk);
    chk("seq1_we", mem_we, 1);
    chk("seq1_addr", mem_addr, 12'h005);
    chk("seq1_data", mem_wdata, 7);

    foreach (tbl[i]) begin
      beat(tbl[i].n, tbl[i].w, 1'b1, 1'b1, 16, 1'b0);
      idle_beat();
      @(negedge clk);
      chk("tbl_wdata", mem_wdata, tbl[i].q_relu);
      chk("tbl_wdata_norelu", nr_wdata, tbl[i].q_norelu);
    end

    beat(32767, 127, 1'b1, 1'b0, 0, 1'b0);
    beat(32767, 127, 1'b0, 1'b0, 0, 1'b0);
    beat(32767, 127, 1'b0, 1'b1, 32, 1'b0);
    idle_beat();
    @(negedge clk);
    chk("sat_data", mem_wdata, 16'h7FFF);
    chk("sat_data_norelu", nr_wdata, 16'h7FFF);

    // back-to-back writes, done on the last one
    start();
    for (int i = 0; i < 4; i++) beat(128, 10, 1'b1, 1'b1, i, i == 3);
    idle_beat();
    @(negedge clk);
    chk("b2b_last_we", mem_we, 1);
    chk("b2b_last_addr", mem_addr, 3);
    chk("flush_busy", busy, 1);
    idle_beat();
    @(negedge clk);
    chk("done_pulse", layer_done, 1);
    chk("done_busy", busy, 0);
    chk("b2b_count", neuron_count, 4);
    for (int i = 0; i < 3; i++) beat(100, 100, 1'b1, 1'b1, 7, 1'b0);
    @(negedge clk);
    chk("done_hold_count", neuron_count, 4);
    chk("done_hold_busy", busy, 0);
    run = 1'b0;
    tick();
    @(negedge clk);
    chk("idle_count_held", neuron_count, 4);
    run = 1'b1;
    tick();
    mact = 1'b1; msum = 0; mcount = 0;
    @(negedge clk);
    chk("restart_count", neuron_count, 0);
    chk("restart_busy", busy, 1);

    // reset one cycle after a write+done beat drops everything
    beat(300, 50, 1'b1, 1'b1, 9, 1'b1);
    reset = 1'b1;
    cancel();
    mact = 1'b0;
    tick();
    @(negedge clk);
    chk("rstflush_we", mem_we, 0);
    chk("rstflush_addr", mem_addr, 0);
    chk("rstflush_data", mem_wdata, 0);
    chk("rstflush_ld", layer_done, 0);
    chk("rstflush_busy", busy, 0);
    chk("rstflush_count", neuron_count, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) idle_beat();

    // randomized layers
    for (int l = 0; l < 2; l++) begin
      start();
      for (int i = 0; i < 300; i++) begin
        int n, w;
        n = int'(shortint'($urandom));
        w = int'(byte'($urandom));
        if ($urandom_range(0, 9) == 0) n = ($urandom_range(0, 1) == 0) ? 32767 : -32768;
        if ($urandom_range(0, 9) == 0) w = ($urandom_range(0, 1) == 0) ? 127 : -128;
        beat(n, w, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
             int'($urandom_range(0, 4095)), i == 299);
      end
      idle_beat();
      idle_beat();
      @(negedge clk);
      chk("rand_count", neuron_count, mcount % 4096);
      chk("rand_busy", busy, 0);
    end

    idle_beat();
    idle_beat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mac_writeback_3.md
Name: mac_writeback_3

Overview:
- Stage-3 consumer of the MLP pipeline. Sits at the receiving end of the stage-2→3 pipeline buffer and takes its registered outputs: done_3, neuron_val_3, weight_val_3, reset_mult_acc_3, out_neuron_addr_3, write_neuron_3.
- Multiply-accumulates neuron × weight products per output neuron.
- On write_neuron_3, requantizes the sum (shift, optional ReLU, saturate to 16 bits) and issues one write to the output neuron memory.
- Reports layer completion once all pending writes have drained.

Parameters:
- ACC_W, 32, accumulator width (signed, two's complement).
- SHIFT, 7, arithmetic right shift applied to the final sum (Q-format rescale for 8-bit weights).
- RELU_EN, 1, 1 = clamp negative results to 0 before saturation.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  layer enable; low forces IDLE and clears state like reset (except neuron_count, see below).
- done_3  input  1  last valid beat of the layer.
- neuron_val_3  input  16  signed input activation.
- weight_val_3  input  8  signed weight.
- reset_mult_acc_3  input  1  this beat starts a new neuron sum.
- out_neuron_addr_3  input  12  destination address of the current neuron.
- write_neuron_3  input  1  this beat is the last term of the current neuron.
- mem_we  output  1  output neuron memory write enable.
- mem_addr  output  12  write address.
- mem_wdata  output  16  requantized neuron value.
- layer_done  output  1  one-cycle pulse when the layer is fully written.
- busy  output  1  high in ACTIVE or FLUSH.
- neuron_count  output  12  number of writes issued this layer.

Behaviour:
- Reset / run low:
  - Reset values: mem_we=0, mem_addr=0, mem_wdata=0, layer_done=0, busy=0, neuron_count=0, accumulator=0.
  - State goes to IDLE; both pipeline valid bits are cleared, so pending writes are discarded.
  - run low clears the same registers except neuron_count, which is held until the next run rising edge.
- States: IDLE, ACTIVE, FLUSH, DONE.
  - IDLE→ACTIVE when run=1. On entry, neuron_count clears to 0.
  - ACTIVE→FLUSH on a beat with done_3=1. That beat's MAC/write is still processed.
  - FLUSH lasts exactly 2 cycles (pipeline depth), then →DONE with layer_done=1 for that single cycle.
  - DONE holds, ignoring all inputs, until run=0 → IDLE.
  - In IDLE and DONE, MAC inputs are ignored and no writes occur.
- MAC, in ACTIVE each cycle:
  - product = signed(neuron_val_3) × signed(weight_val_3), 24-bit, sign-extended to ACC_W.
  - acc_next = (reset_mult_acc_3 ? 0 : acc) + product.
  - The accumulator wraps modulo 2^ACC_W with no saturation.
  - An all-zero beat (both values 0, no flags) is a valid no-op term.
- Write pipeline, 2-cycle latency from the write_neuron_3 beat to mem_we:
  - Stage A (edge of the write beat): latch acc_next, out_neuron_addr_3, valid.
  - Stage B (next edge): r = acc_A >>> SHIFT (arithmetic); if RELU_EN and r<0 then r=0; saturate r to [-32768, 32767]. Drive mem_wdata=r, mem_addr=addr_A, mem_we=1 for exactly one cycle.
  - neuron_count increments on each mem_we and wraps at 4096.
- reset_mult_acc_3 and write_neuron_3 on the same beat: single-term neuron, value = product.
- Back-to-back write_neuron_3 on consecutive cycles must produce consecutive mem_we pulses with no loss. The pipeline is fully pipelined, with no stalls and no backpressure.
- The accumulator is not auto-cleared after a write. A following beat without reset_mult_acc_3 continues the sum, and that is legal.
- done_3 together with write_neuron_3: the write completes during FLUSH, and mem_we precedes layer_done by exactly one cycle.
- reset during FLUSH: the pending write is dropped and layer_done never fires.

Test Plan:
- Reset, then run=1. Beats (neuron,weight,flags): (256,2,rst), (128,-1,-), (512,1,write, addr=0x005). Sum=512−128+512=896, >>>7 = 7 → mem_we=1, mem_addr=0x005, mem_wdata=7, exactly 2 cycles after the write beat.
- Single beat (-1000,100,rst+write, addr=0x010), RELU_EN=1 → mem_wdata=0. Same beat with RELU_EN=0 → −100000>>>7 = −782 → mem_wdata=0xFCF2.
- Saturation: (32767,127,rst+write) → 4161409>>>7 = 32511, no clip. Then three beats of (32767,127) with write on the third → 12484227>>>7 = 97533 → mem_wdata=32767.
- Back-to-back: four consecutive rst+write beats (10×128, addrs 0–3) → four consecutive mem_we cycles, each data=10; neuron_count=4.
- done_3 on the last write beat → mem_we at +2 cycles, layer_done pulse at +3, busy=0 from +3. With run held high, further input beats cause no writes. Then run=0 → IDLE, run=1 → neuron_count=0.
- reset asserted 1 cycle after a write beat → no mem_we, no layer_done; all outputs 0 next cycle.
